smg_display_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller driving DIGITS common-select digits from a packed hex value. Adds four features to the fixed 6-digit scan path:
- per-digit decimal points
- per-digit blank and blink masks
- 8-level PWM brightness
- tear-free frame-synchronous data loading

Sits between the application datapath (counters, keypad logic) and the board's SMG pins.

---
 rtl/smg_pkg.sv | 24 ++
 rtl/smg_hex_decoder.sv | 16 +
 rtl/smg_display_ctrl.sv | 126 ++++++++++++
 tb/tb_smg_display_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared constants for the seven-segment display path: segment bit order,
// the active-high hex glyph table and the blank pattern.
package smg_pkg;

   typedef enum logic [2:0] {
      SEG_A  = 3'd0,
      SEG_B  = 3'd1,
      SEG_C  = 3'd2,
      SEG_D  = 3'd3,
      SEG_E  = 3'd4,
      SEG_F  = 3'd5,
      SEG_G  = 3'd6,
      SEG_DP = 3'd7
   } seg_bit_e;

   localparam logic [7:0] SEG_OFF_AH = 8'h00;

   // Glyphs for 0..9, A, b, C, d, E, F with bit 7 (dp) clear.
   localparam logic [7:0] HEX_SEG_AH [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

endpackage

// File: rtl/smg_hex_decoder.sv
// Combinational nibble + decimal point to active-high segment pattern.
// Pin polarity is applied by the parent.
module smg_hex_decoder
   import smg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg         = HEX_SEG_AH[nibble];
      seg[SEG_DP] = dp;
   end

endmodule

// File: rtl/smg_display_ctrl.sv
// Multiplexed seven-segment scanner with per-digit dp, blank/blink masks,
// 8-level PWM brightness and frame-synchronous (tear-free) data loading.
module smg_display_ctrl
   import smg_pkg::*;
#(
   parameter int DIGITS         = 6,
   parameter int SCAN_DIV       = 50000,
   parameter int BLINK_FRAMES   = 25,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
)
(
   input  logic                  CLK,
   input  logic                  RSTn,
   input  logic [4*DIGITS-1:0]   Number_Sig,
   input  logic [DIGITS-1:0]     Dp_Sig,
   input  logic [DIGITS-1:0]     Blank_Mask,
   input  logic [DIGITS-1:0]     Blink_Mask,
   input  logic [2:0]            Brightness,
   input  logic                  Load,
   output logic [7:0]            SMG_Data,
   output logic [DIGITS-1:0]     Scan_Sig
);

   localparam int DWELL_W  = $clog2(SCAN_DIV);
   localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int FRAME_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int SLOT_LEN = SCAN_DIV / 8;

   localparam logic [7:0]        SEG_OFF_PIN = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF_AH : SEG_OFF_AH;
   localparam logic [DIGITS-1:0] SEL_OFF_PIN = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

   logic [DWELL_W-1:0]  dwell;
   logic [IDX_W-1:0]    idx;
   logic [FRAME_W-1:0]  frame_cnt;
   logic                blink_phase;

   logic [4*DIGITS-1:0] cap_num,   disp_num;
   logic [DIGITS-1:0]   cap_dp,    disp_dp;
   logic [DIGITS-1:0]   cap_blank, disp_blank;
   logic [DIGITS-1:0]   cap_blink, disp_blink;

   logic                dwell_wrap;
   logic                idx_wrap;
   logic                frame_end;
   logic                frame_wrap;
   logic [3:0]          nibble;
   logic                dp_bit;
   logic [7:0]          seg_ah;
   logic                pwm_on;
   logic                dark;
   logic [7:0]          seg_next;
   logic [DIGITS-1:0]   sel_next;

   smg_hex_decoder u_dec (
      .nibble (nibble),
      .dp     (dp_bit),
      .seg    (seg_ah)
   );

   // Pin pattern for the digit selected this cycle; registered on the next edge.
   always_comb begin
      dwell_wrap = (dwell == DWELL_W'(SCAN_DIV - 1));
      idx_wrap   = (idx == IDX_W'(DIGITS - 1));
      frame_end  = dwell_wrap && idx_wrap;
      frame_wrap = (frame_cnt == FRAME_W'(BLINK_FRAMES - 1));
      nibble     = 4'(disp_num >> {idx, 2'b00});
      dp_bit     = disp_dp[idx];
      pwm_on     = int'(dwell) < (int'(Brightness) + 1) * SLOT_LEN;
      dark       = disp_blank[idx] || (disp_blink[idx] && blink_phase) || !pwm_on;
      seg_next   = SEG_OFF_PIN;
      sel_next   = SEL_OFF_PIN;
      if (!dark) begin
         seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
         sel_next = (SEL_ACTIVE_LOW != 0) ? ~(DIGITS'(1) << idx) : (DIGITS'(1) << idx);
      end
   end

   // The display copy is taken on the wrap edge, so a coincident Load lands a frame later.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         dwell       <= '0;
         idx         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         cap_num     <= '0;
         cap_dp      <= '0;
         cap_blank   <= '0;
         cap_blink   <= '0;
         disp_num    <= '0;
         disp_dp     <= '0;
         disp_blank  <= '0;
         disp_blink  <= '0;
         SMG_Data    <= SEG_OFF_PIN;
         Scan_Sig    <= SEL_OFF_PIN;
      end else begin
         SMG_Data <= seg_next;
         Scan_Sig <= sel_next;
         if (Load) begin
            cap_num   <= Number_Sig;
            cap_dp    <= Dp_Sig;
            cap_blank <= Blank_Mask;
            cap_blink <= Blink_Mask;
         end
         if (dwell_wrap) begin
            dwell <= '0;
            idx   <= idx_wrap ? '0 : idx + 1'b1;
         end else begin
            dwell <= dwell + 1'b1;
         end
         if (frame_end) begin
            disp_num   <= cap_num;
            disp_dp    <= cap_dp;
            disp_blank <= cap_blank;
            disp_blink <= cap_blink;
            if (frame_wrap) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_smg_display_ctrl.sv
// Bench for smg_display_ctrl: a time-indexed model of the scan is checked every
// cycle, with directed literal checks pinning key moments.
module tb_smg_display_ctrl;

   localparam int DIGITS       = 6;
   localparam int SCAN_DIV     = 16;
   localparam int BLINK_FRAMES = 2;
   localparam int FRAME_LEN    = DIGITS * SCAN_DIV;

   logic                CLK = 1'b0;
   logic                RSTn = 1'b0;
   logic [4*DIGITS-1:0] Number_Sig = '0;
   logic [DIGITS-1:0]   Dp_Sig = '0;
   logic [DIGITS-1:0]   Blank_Mask = '0;
   logic [DIGITS-1:0]   Blink_Mask = '0;
   logic [2:0]          Brightness = 3'd7;
   logic                Load = 1'b0;
   logic [7:0]          SMG_Data;
   logic [DIGITS-1:0]   Scan_Sig;

   int checks = 0;
   int errors = 0;

   smg_display_ctrl #(
      .DIGITS         (DIGITS),
      .SCAN_DIV       (SCAN_DIV),
      .BLINK_FRAMES   (BLINK_FRAMES),
      .SEG_ACTIVE_LOW (1),
      .SEL_ACTIVE_LOW (1)
   ) dut (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .Number_Sig (Number_Sig),
      .Dp_Sig     (Dp_Sig),
      .Blank_Mask (Blank_Mask),
      .Blink_Mask (Blink_Mask),
      .Brightness (Brightness),
      .Load       (Load),
      .SMG_Data   (SMG_Data),
      .Scan_Sig   (Scan_Sig)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [7:0] exp_seg_v,
                              input logic [DIGITS-1:0] exp_scan_v);
      checks++;
      if (SMG_Data !== exp_seg_v || Scan_Sig !== exp_scan_v) begin
         errors++;
         $display("[TB] FAIL %s: got SMG_Data=%h Scan_Sig=%b, want %h %b at %0t",
                  name, SMG_Data, Scan_Sig, exp_seg_v, exp_scan_v, $time);
      end
   endtask

   // Model: t counts cycles since reset release; digit, dwell position, frame
   // and blink phase follow arithmetically from it.
   logic [7:0]          hex_ah [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
   bit                  model_valid = 1'b0;
   int                  t, digit, pos, frame, phase;
   logic [3:0]          nib;
   logic [7:0]          exp_seg;
   logic [DIGITS-1:0]   exp_scan;
   logic [4*DIGITS-1:0] m_cap_num, m_disp_num;
   logic [DIGITS-1:0]   m_cap_dp, m_disp_dp, m_cap_blank, m_disp_blank, m_cap_blink, m_disp_blink;

   always @(negedge CLK) begin
      if (model_valid) checkOutput("model", exp_seg, exp_scan);
      if (!RSTn) begin
         model_valid = 1'b1;
         exp_seg     = 8'hFF;
         exp_scan    = '1;
         t           = 0;
         m_cap_num   = '0; m_disp_num   = '0;
         m_cap_dp    = '0; m_disp_dp    = '0;
         m_cap_blank = '0; m_disp_blank = '0;
         m_cap_blink = '0; m_disp_blink = '0;
      end else if (model_valid) begin
         digit = (t / SCAN_DIV) % DIGITS;
         pos   = t % SCAN_DIV;
         frame = t / FRAME_LEN;
         phase = (frame / BLINK_FRAMES) % 2;
         nib   = 4'(m_disp_num >> (4 * digit));
         if (!m_disp_blank[digit] && !(m_disp_blink[digit] && phase == 1) &&
             (pos / (SCAN_DIV / 8)) <= int'(Brightness)) begin
            exp_seg  = ~(hex_ah[nib] | {m_disp_dp[digit], 7'b0});
            exp_scan = ~(DIGITS'(1) << digit);
         end else begin
            exp_seg  = 8'hFF;
            exp_scan = '1;
         end
         if (t % FRAME_LEN == FRAME_LEN - 1) begin
            m_disp_num   = m_cap_num;
            m_disp_dp    = m_cap_dp;
            m_disp_blank = m_cap_blank;
            m_disp_blink = m_cap_blink;
         end
         if (Load) begin
            m_cap_num   = Number_Sig;
            m_cap_dp    = Dp_Sig;
            m_cap_blank = Blank_Mask;
            m_cap_blink = Blink_Mask;
         end
         t++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic [4*DIGITS-1:0] num, input logic [DIGITS-1:0] dp,
                                input logic [DIGITS-1:0] blank, input logic [DIGITS-1:0] blink,
                                input logic [2:0] bright, input logic load);
      Number_Sig = num;
      Dp_Sig     = dp;
      Blank_Mask = blank;
      Blink_Mask = blink;
      Brightness = bright;
      Load       = load;
   endtask

   initial begin
      tick(3);
      checkOutput("reset_hold", 8'hFF, 6'b111111);

      // Release (cycle 0) with a Load of 012345.
      RSTn = 1'b1;
      applyStimulus(24'h012345, '0, '0, '0, 3'd7, 1'b1);
      tick(1);
      Load = 1'b0;
      checkOutput("first_lit_old_disp", 8'hC0, 6'b111110);
      tick(96);
      checkOutput("d0_five_start", 8'h92, 6'b111110);
      tick(15);
      checkOutput("d0_five_end", 8'h92, 6'b111110);
      tick(1);
      checkOutput("d1_four", 8'h99, 6'b111101);

      // Load mid-frame, then again exactly on the boundary cycle (state 191).
      applyStimulus(24'hABCDEF, '0, '0, '0, 3'd7, 1'b1);
      tick(1);
      Load = 1'b0;
      tick(77);
      applyStimulus(24'h111111, '0, '0, '0, 3'd7, 1'b1);
      tick(1);
      Load = 1'b0;
      tick(1);
      checkOutput("abcdef_d0_F", 8'h8E, 6'b111110);
      tick(80);
      checkOutput("abcdef_d5_A", 8'h88, 6'b011111);
      tick(16);
      checkOutput("late_111111", 8'hF9, 6'b111110);

      // PWM: Brightness=1 lights dwell 0..3, Brightness=0 lights dwell 0..1.
      Brightness = 3'd1;
      tick(96);
      checkOutput("b1_dwell0", 8'hF9, 6'b111110);
      tick(3);
      checkOutput("b1_dwell3", 8'hF9, 6'b111110);
      tick(1);
      checkOutput("b1_dwell4_dark", 8'hFF, 6'b111111);
      Brightness = 3'd0;
      tick(92);
      checkOutput("b0_dwell0", 8'hF9, 6'b111110);
      tick(1);
      checkOutput("b0_dwell1", 8'hF9, 6'b111110);
      tick(1);
      checkOutput("b0_dwell2_dark", 8'hFF, 6'b111111);

      // Blink digit 0, blank digit 2.
      applyStimulus(24'h111111, '0, 6'b000100, 6'b000001, 3'd7, 1'b1);
      tick(1);
      Load = 1'b0;
      tick(93);
      checkOutput("blink_off_d0", 8'hFF, 6'b111111);
      tick(16);
      checkOutput("blink_d1_lit", 8'hF9, 6'b111101);
      tick(16);
      checkOutput("blank_d2", 8'hFF, 6'b111111);
      tick(160);
      checkOutput("blink_on_d0", 8'hF9, 6'b111110);

      // Decimal point on digit 1 showing 8.
      applyStimulus(24'h111181, 6'b000010, '0, '0, 3'd7, 1'b1);
      tick(1);
      Load = 1'b0;
      tick(95);
      checkOutput("dp_d0_plain", 8'hF9, 6'b111110);
      tick(16);
      checkOutput("dp_d1_eight", 8'h00, 6'b111101);

      // Reset mid-dwell of digit 3.
      tick(39);
      RSTn = 1'b0;
      tick(1);
      checkOutput("reset_mid_frame", 8'hFF, 6'b111111);
      tick(2);
      RSTn = 1'b1;
      tick(1);
      checkOutput("restart_d0_zero", 8'hC0, 6'b111110);
      tick(120);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
